// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation, built on an
// interleaved shift-add modular multiplier (one multiplier bit per cycle).
module mod_exp_engine #(
  parameter int ARQ = 16
) (
  input  logic [2*ARQ-1:0] base,
  input  logic [2*ARQ-1:0] modulo,
  input  logic [2*ARQ-1:0] exponent,
  input  logic             clk,
  input  logic             reset,
  output logic             finish,
  output logic [2*ARQ-1:0] result
);

  localparam int W  = 2 * ARQ;
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {LOAD, REDUCE, CHECK, MUL, SQR, DONE} state_t;

  state_t          state;
  logic [W-1:0]    m_reg;
  logic [W-1:0]    e_reg;
  logic [W-1:0]    base_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    acc_reg;
  logic [W+1:0]    r_reg;
  logic [CW-1:0]   cnt_reg;

  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_x;
  logic [CW-1:0]   bit_idx;
  logic [W+1:0]    m_ext;
  logic [W+1:0]    r_dbl;
  logic [W+1:0]    r_s1;
  logic [W+1:0]    r_next;
  logic            mul_last;

  // Operand selection for the shared multiplier; REDUCE uses a=1 so the
  // multiplier yields base mod m.
  always_comb begin
    mul_a = '0;
    mul_x = '0;
    case (state)
      REDUCE: begin
        mul_a = {{(W-1){1'b0}}, 1'b1};
        mul_x = base_reg;
      end
      MUL: begin
        mul_a = acc_reg;
        mul_x = b_reg;
      end
      SQR: begin
        mul_a = b_reg;
        mul_x = b_reg;
      end
      default: ;
    endcase
  end

  // One shift-add step: r < m and a < m, so 2r + a < 3m; two subtractions suffice.
  always_comb begin
    bit_idx  = CW'(W - 1) - cnt_reg;
    m_ext    = {2'b00, m_reg};
    r_dbl    = (r_reg << 1) + (mul_x[bit_idx] ? {2'b00, mul_a} : '0);
    r_s1     = (r_dbl >= m_ext) ? (r_dbl - m_ext) : r_dbl;
    r_next   = (r_s1 >= m_ext) ? (r_s1 - m_ext) : r_s1;
    mul_last = (cnt_reg == CW'(W - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOAD;
      m_reg    <= '0;
      e_reg    <= '0;
      base_reg <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      r_reg    <= '0;
      cnt_reg  <= '0;
      finish   <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        LOAD: begin
          m_reg    <= modulo;
          e_reg    <= exponent;
          base_reg <= base;
          acc_reg  <= {{(W-1){1'b0}}, 1'b1};
          r_reg    <= '0;
          cnt_reg  <= '0;
          if (modulo <= {{(W-1){1'b0}}, 1'b1}) begin
            result <= '0;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            state  <= REDUCE;
          end
        end

        REDUCE, MUL, SQR: begin
          if (mul_last) begin
            r_reg   <= '0;
            cnt_reg <= '0;
            case (state)
              REDUCE: begin
                b_reg <= r_next[W-1:0];
                state <= CHECK;
              end
              MUL: begin
                acc_reg <= r_next[W-1:0];
                state   <= SQR;
              end
              default: begin
                b_reg <= r_next[W-1:0];
                e_reg <= e_reg >> 1;
                state <= CHECK;
              end
            endcase
          end else begin
            r_reg   <= r_next;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        CHECK: begin
          if (e_reg == '0) begin
            result <= acc_reg;
            finish <= 1'b1;
            state  <= DONE;
          end else if (e_reg[0]) begin
            state <= MUL;
          end else begin
            state <= SQR;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed-vector bench for mod_exp_engine: known RSA-style results, edge
// cases, asynchronous abort and a full-width Fermat stress case.
module tb_mod_exp_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] base = '0;
  logic [31:0] modulo = '0;
  logic [31:0] exponent = '0;
  logic        finish;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  mod_exp_engine #(.ARQ(16)) dut (
    .base(base),
    .modulo(modulo),
    .exponent(exponent),
    .clk(clk),
    .reset(reset),
    .finish(finish),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, " reset finish"}, {31'd0, finish}, 32'd0);
    check({tag, " reset result"}, result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_case(input logic [31:0] b, input logic [31:0] m, input logic [31:0] e,
                          input logic [31:0] exp, input string tag, output int cycles);
    bit seen;
    base = b;
    modulo = m;
    exponent = e;
    do_reset(tag);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (finish) seen = 1'b1;
    end
    check({tag, " finish"}, {31'd0, finish}, 32'd1);
    check({tag, " result"}, result, exp);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold finish"}, {31'd0, finish}, 32'd1);
    check({tag, " hold result"}, result, exp);
    $display("case %s: base=%0d mod=%0d exp=%0d result=%0d cycles=%0d",
             tag, b, m, e, result, cycles);
  endtask

  initial begin
    #1;
    check("init finish", {31'd0, finish}, 32'd0);
    check("init result", result, 32'd0);

    run_case(32'd150, 32'd1927, 32'd1349, 32'd260, "rsa", cyc);
    run_case(32'd4, 32'd497, 32'd13, 32'd445, "small", cyc);
    run_case(32'd2, 32'd1000, 32'd10, 32'd24, "pow2", cyc);
    // e=1010b: 1 + 32 + 5 checks + 4 squares*32 + 2 multiplies*32
    check("pow2 latency", cyc, 32'd230);
    run_case(32'd150, 32'd1927, 32'd0, 32'd1, "exp0", cyc);
    run_case(32'd3000, 32'd1927, 32'd1, 32'd1073, "base_ge_m", cyc);
    run_case(32'd0, 32'd1927, 32'd5, 32'd0, "base0", cyc);
    run_case(32'd12345, 32'd1, 32'd77, 32'd0, "mod1", cyc);
    check("mod1 latency<=2", {31'd0, cyc <= 2}, 32'd1);

    // Abort mid-computation, then restart with different inputs.
    base = 32'd150;
    modulo = 32'd1927;
    exponent = 32'd1349;
    do_reset("abort start");
    repeat (500) @(posedge clk);
    #1;
    check("abort midrun finish", {31'd0, finish}, 32'd0);
    do_reset("abort");
    run_case(32'd4, 32'd497, 32'd13, 32'd445, "after_abort", cyc);

    run_case(32'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd1, "fermat", cyc);
    check("fermat latency bound", {31'd0, cyc <= 2116}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
